// File: rtl/exception_ctrl_pkg.sv
// Shared constants and types for the MEM-stage exception arbiter:
// exception codes, CP0 register addresses, flag bit indices and FSM/state encodings.
package exception_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int unsigned FLAG_FETCH_ADEL = 0;
    localparam int unsigned FLAG_RI         = 1;
    localparam int unsigned FLAG_SYSCALL    = 2;
    localparam int unsigned FLAG_BREAK      = 3;
    localparam int unsigned FLAG_OVERFLOW   = 4;
    localparam int unsigned FLAG_TRAP       = 5;
    localparam int unsigned FLAG_LOAD_ADEL  = 6;
    localparam int unsigned FLAG_STORE_ADES = 7;

    localparam int unsigned STATUS_IE    = 0;
    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned STATUS_IM_LO = 8;
    localparam int unsigned STATUS_IM_HI = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BAD_NONE = 2'd0,
        BAD_PC   = 2'd1,
        BAD_ADDR = 2'd2
    } bad_sel_t;

endpackage

// File: rtl/exception_ctrl_priority_enc.sv
// Combinational priority encoder: picks the highest-priority exception for the
// MEM-stage instruction and says where its BadVAddr comes from.
module exc_priority_enc
    import exception_ctrl_pkg::*;
(
    input  logic [7:0]  exc,
    input  logic        int_pending,
    input  logic        eret,
    output logic [31:0] code,
    output bad_sel_t    bad_sel
);

    always_comb begin
        code    = '0;
        bad_sel = BAD_NONE;
        if (int_pending) begin
            code = EXC_INT;
        end else if (exc[FLAG_FETCH_ADEL]) begin
            code    = EXC_ADEL;
            bad_sel = BAD_PC;
        end else if (exc[FLAG_RI]) begin
            code = EXC_RI;
        end else if (exc[FLAG_SYSCALL]) begin
            code = EXC_SYS;
        end else if (exc[FLAG_BREAK]) begin
            code = EXC_BP;
        end else if (exc[FLAG_OVERFLOW]) begin
            code = EXC_OV;
        end else if (exc[FLAG_TRAP]) begin
            code = EXC_TR;
        end else if (exc[FLAG_LOAD_ADEL]) begin
            code    = EXC_ADEL;
            bad_sel = BAD_ADDR;
        end else if (exc[FLAG_STORE_ADES]) begin
            code    = EXC_ADES;
            bad_sel = BAD_ADDR;
        end else if (eret) begin
            code = EXC_ERET;
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception arbiter: forwards in-flight mtc0 writes, resolves priority
// and issues one registered commit/flush per exception, followed by a blanked cycle.
module exception_ctrl
    import exception_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        mem_stall_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [7:0]  mem_exc_i,
    input  logic        mem_eret_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    logic [31:0] status_eff;
    logic [31:0] cause_eff;
    logic [31:0] epc_eff;
    logic        int_pending;
    logic [31:0] code;
    bad_sel_t    bad_sel;
    logic [31:0] bad_val;
    logic        commit;

    state_t      state;
    state_t      state_next;

    logic [31:0] lat_type;
    logic [31:0] lat_pc;
    logic        lat_ds;
    logic [31:0] lat_bad;
    logic [31:0] lat_new_pc;

    // An mtc0 retiring this cycle must be visible to the interrupt check and eret target.
    always_comb begin
        status_eff = cp0_status_i;
        cause_eff  = cp0_cause_i;
        epc_eff    = cp0_epc_i;
        if (cp0_we_i) begin
            if (cp0_waddr_i == CP0_STATUS) status_eff = cp0_wdata_i;
            if (cp0_waddr_i == CP0_EPC)    epc_eff    = cp0_wdata_i;
            if (cp0_waddr_i == CP0_CAUSE)  cause_eff[9:8] = cp0_wdata_i[9:8];
        end
    end

    always_comb begin
        int_pending = status_eff[STATUS_IE] && !status_eff[STATUS_EXL] &&
                      ((cause_eff[STATUS_IM_HI:STATUS_IM_LO] &
                        status_eff[STATUS_IM_HI:STATUS_IM_LO]) != '0);
    end

    logic unused_bits;
    assign unused_bits = ^{status_eff[31:16], status_eff[7:2],
                           cause_eff[31:16], cause_eff[7:0]};

    exc_priority_enc u_prio (
        .exc         (mem_exc_i),
        .int_pending (int_pending),
        .eret        (mem_eret_i),
        .code        (code),
        .bad_sel     (bad_sel)
    );

    always_comb begin
        unique case (bad_sel)
            BAD_PC:   bad_val = mem_pc_i;
            BAD_ADDR: bad_val = mem_addr_i;
            default:  bad_val = '0;
        endcase
    end

    assign commit = (state == ST_IDLE) && mem_valid_i && !mem_stall_i && (code != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (commit) state_next = ST_FLUSH;
            ST_FLUSH: state_next = ST_BLANK;
            ST_BLANK: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_type   <= '0;
            lat_pc     <= '0;
            lat_ds     <= 1'b0;
            lat_bad    <= '0;
            lat_new_pc <= '0;
        end else if (commit) begin
            lat_type   <= code;
            lat_pc     <= mem_pc_i;
            lat_ds     <= mem_in_delayslot_i;
            lat_bad    <= bad_val;
            lat_new_pc <= (code == EXC_ERET) ? epc_eff : EXC_VECTOR;
        end
    end

    // Outputs are gated by the registered state, so reset blanks them asynchronously.
    always_comb begin
        excepttype_o        = '0;
        current_inst_addr_o = '0;
        is_in_delayslot_o   = 1'b0;
        bad_addr_o          = '0;
        flush_o             = 1'b0;
        new_pc_o            = '0;
        if (state == ST_FLUSH) begin
            excepttype_o        = lat_type;
            current_inst_addr_o = lat_pc;
            is_in_delayslot_o   = lat_ds;
            bad_addr_o          = lat_bad;
            flush_o             = 1'b1;
            new_pc_o            = lat_new_pc;
        end
    end

endmodule
